// File: rtl/scarv_cop_mem_arbiter_pkg.sv
// scarv_cop_mem_arbiter_pkg: grant FSM state encodings and port ids shared by the arbiter and its picker
package scarv_cop_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;
  typedef enum logic {
    ARB_P0 = 1'b0,
    ARB_P1 = 1'b1
  } arb_port_e;
endpackage

// File: rtl/scarv_cop_mem_arb_pick.sv
// scarv_cop_mem_arb_pick: combinational winner select; round-robin when SCARV_COP_MEM_ARB_RR_EN is defined, otherwise fixed P0 priority with a consec-count override for P1
module scarv_cop_mem_arb_pick
  import scarv_cop_mem_arbiter_pkg::*;
#(
  parameter int MAX_CONSEC = 4,
  parameter int CW = $clog2(MAX_CONSEC + 1)
) (
  input  logic          p0_cen,
  input  logic          p1_cen,
  input  arb_port_e     last,
  input  logic [CW-1:0] consec,
  output arb_port_e     win
);
`ifdef SCARV_COP_MEM_ARB_RR_EN
  logic unused_consec;
  assign unused_consec = ^consec;
  assign win = p1_cen & (!p0_cen | last == ARB_P0) ? ARB_P1 : ARB_P0;
`else
  localparam logic [CW-1:0] MAXC = CW'(MAX_CONSEC);
  logic unused_last;
  assign unused_last = last == ARB_P1;
  assign win = p1_cen & (!p0_cen | consec == MAXC) ? ARB_P1 : ARB_P0;
`endif
endmodule

// File: rtl/scarv_cop_mem_arbiter.sv
// scarv_cop_mem_arbiter: shares one memory port between host (P0) and COP LSU (P1); SCARV_COP_MEM_ARB_RR_EN selects round-robin over fixed priority
module scarv_cop_mem_arbiter
  import scarv_cop_mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_CONSEC = 4
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  output logic          g_clk_req,
  input  logic          p0_cen,
  input  logic          p0_wen,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [DW/8-1:0] p0_ben,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_stall,
  output logic          p0_error,
  input  logic          p1_cen,
  input  logic          p1_wen,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic [DW/8-1:0] p1_ben,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_stall,
  output logic          p1_error,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_ben,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_stall,
  input  logic          mem_error
);
  localparam int CW = $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_CONSEC);
  arb_state_e state_q, state_d;
  arb_port_e last_q, last_d, win;
  logic [CW-1:0] consec_q, consec_d;
  logic own0, own1, grant, done;
  scarv_cop_mem_arb_pick #(.MAX_CONSEC(MAX_CONSEC), .CW(CW)) u_pick (
    .p0_cen (p0_cen),
    .p1_cen (p1_cen),
    .last   (last_q),
    .consec (consec_q),
    .win    (win)
  );
  assign own0 = state_q == ARB_OWN0;
  assign own1 = state_q == ARB_OWN1;
  assign grant = state_q == ARB_IDLE & (p0_cen | p1_cen);
  assign g_clk_req = p0_cen | p1_cen | state_q != ARB_IDLE;
  assign mem_cen = own0 & p0_cen | own1 & p1_cen;
  assign done = mem_cen & !mem_stall;
  assign mem_wen = mem_cen & (own1 ? p1_wen : p0_wen);
  assign mem_addr = mem_cen ? (own1 ? p1_addr : p0_addr) : '0;
  assign mem_wdata = mem_cen ? (own1 ? p1_wdata : p0_wdata) : '0;
  assign mem_ben = mem_cen ? (own1 ? p1_ben : p0_ben) : '0;
  assign p0_stall = own0 ? mem_stall : p0_cen;
  assign p1_stall = own1 ? mem_stall : p1_cen;
  assign p0_rdata = own0 & done ? mem_rdata : '0;
  assign p1_rdata = own1 & done ? mem_rdata : '0;
  assign p0_error = own0 & done & mem_error;
  assign p1_error = own1 & done & mem_error;
  assign consec_d = !p1_cen | grant & win == ARB_P1 ? '0 :
                    grant & consec_q != MAXC ? consec_q + 1'b1 : consec_q;
  // Grant from IDLE to the picked port; drop back to IDLE on completion or abort
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (grant) begin
      state_d = win == ARB_P0 ? ARB_OWN0 : ARB_OWN1;
      last_d  = win;
    end else if (state_q != ARB_IDLE && !(mem_cen && mem_stall)) begin
      state_d = ARB_IDLE;
    end
  end
  // State, last-grant and anti-starvation counter registers
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q  <= ARB_IDLE;
      last_q   <= ARB_P1;
      consec_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      consec_q <= consec_d;
    end
  end
endmodule

// File: tb/tb_scarv_cop_mem_arbiter.sv
// tb_scarv_cop_mem_arbiter: directed stimulus with a transaction-level model checked every cycle
module tb_scarv_cop_mem_arbiter;
  localparam int MAXC = 4;
`ifdef SCARV_COP_MEM_ARB_RR_EN
  localparam int EXP_RUN = 1;
`else
  localparam int EXP_RUN = MAXC;
`endif
  logic g_clk = 1'b0, g_resetn = 1'b0, g_clk_req;
  logic p0_cen, p0_wen, p0_stall, p0_error, p1_cen, p1_wen, p1_stall, p1_error;
  logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic [3:0] p0_ben, p1_ben, mem_ben;
  logic mem_cen, mem_wen, mem_stall, mem_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int n_cmp = 0, n_fail = 0;
  int owner = -1, last = 1, run = 0;
  int n0;
  logic seen;
  always #5 g_clk = ~g_clk;
  scarv_cop_mem_arbiter #(.AW(32), .DW(32), .MAX_CONSEC(MAXC)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req),
    .p0_cen(p0_cen), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ben(p0_ben),
    .p0_rdata(p0_rdata), .p0_stall(p0_stall), .p0_error(p0_error),
    .p1_cen(p1_cen), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ben(p1_ben),
    .p1_rdata(p1_rdata), .p1_stall(p1_stall), .p1_error(p1_error),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ben(mem_ben), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_error(mem_error)
  );
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  // Model: who owns the port, which port was served last, and how many P0 grants P1 has sat through
  always @(negedge g_clk) begin : model
    logic act, fin;
    int w;
    if (!g_resetn) begin
      owner = -1;
      last = 1;
      run = 0;
    end
    act = owner == 0 ? p0_cen : owner == 1 ? p1_cen : 1'b0;
    fin = act & !mem_stall;
    chk("m_mem_cen", mem_cen, act);
    chk("m_mem_wen", mem_wen, act & (owner == 1 ? p1_wen : p0_wen));
    chk("m_mem_addr", mem_addr, act ? (owner == 1 ? p1_addr : p0_addr) : 32'h0);
    chk("m_mem_wdata", mem_wdata, act ? (owner == 1 ? p1_wdata : p0_wdata) : 32'h0);
    chk("m_mem_ben", mem_ben, act ? (owner == 1 ? p1_ben : p0_ben) : 4'h0);
    chk("m_p0_stall", p0_stall, owner == 0 ? mem_stall : p0_cen);
    chk("m_p1_stall", p1_stall, owner == 1 ? mem_stall : p1_cen);
    chk("m_p0_rdata", p0_rdata, owner == 0 && fin ? mem_rdata : 32'h0);
    chk("m_p1_rdata", p1_rdata, owner == 1 && fin ? mem_rdata : 32'h0);
    chk("m_p0_error", p0_error, owner == 0 && fin && mem_error);
    chk("m_p1_error", p1_error, owner == 1 && fin && mem_error);
    chk("m_clk_req", g_clk_req, owner != -1 || p0_cen || p1_cen);
    if (g_resetn) begin
      if (owner == -1) begin
        if (p0_cen || p1_cen) begin
`ifdef SCARV_COP_MEM_ARB_RR_EN
          w = (p1_cen && (!p0_cen || last == 0)) ? 1 : 0;
`else
          w = (p1_cen && (!p0_cen || run == MAXC)) ? 1 : 0;
`endif
          if (w == 1) run = 0;
          else if (p1_cen && run < MAXC) run++;
          last = w;
          owner = w;
        end
      end else if (!(act && mem_stall)) begin
        owner = -1;
      end
      if (!p1_cen) run = 0;
    end
  end
  task automatic step();
    @(posedge g_clk);
    #1;
  endtask
  task automatic at();
    @(negedge g_clk);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    {p0_cen, p0_wen, p1_cen, p1_wen, mem_stall, mem_error} = '0;
    {p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rdata} = '0;
    p0_ben = 4'h0;
    p1_ben = 4'h0;
    p1_cen = 1'b1;
    #2;
    chk("rst_p1_stall", p1_stall, 1);
    chk("rst_p0_stall", p0_stall, 0);
    chk("rst_mem_cen", mem_cen, 0);
    chk("rst_p1_error", p1_error, 0);
    p1_cen = 1'b0;
    step();
    step();
    g_resetn = 1'b1;
    step();
    // single P1 read
    p1_cen = 1'b1; p1_addr = 32'h100; p1_ben = 4'hf; mem_rdata = 32'hDEADBEEF;
    at(); chk("t1_arb_stall", p1_stall, 1); chk("t1_arb_cen", mem_cen, 0);
    step();
    at(); chk("t1_mem_cen", mem_cen, 1); chk("t1_addr", mem_addr, 32'h100);
    chk("t1_rdata", p1_rdata, 32'hDEADBEEF); chk("t1_stall", p1_stall, 0);
    step(); p1_cen = 1'b0;
    at(); chk("t1_rdata_clr", p1_rdata, 0);
    step();
    // simultaneous requests: P0 write first, P1 read two cycles after P0 completes
    p0_cen = 1'b1; p0_wen = 1'b1; p0_addr = 32'h200; p0_wdata = 32'h12345678; p0_ben = 4'h3;
    p1_cen = 1'b1; p1_addr = 32'h300; mem_rdata = 32'hCAFEF00D;
    at(); chk("t2_p0_stall0", p0_stall, 1); chk("t2_p1_stall0", p1_stall, 1);
    step();
    at(); chk("t2_addr0", mem_addr, 32'h200); chk("t2_wen", mem_wen, 1);
    chk("t2_wdata", mem_wdata, 32'h12345678); chk("t2_ben", mem_ben, 4'h3);
    chk("t2_p1_wait", p1_stall, 1); chk("t2_p0_done", p0_stall, 0);
    step(); p0_cen = 1'b0; p0_wen = 1'b0;
    at(); chk("t2_bubble", mem_cen, 0); chk("t2_p1_wait2", p1_stall, 1);
    step();
    at(); chk("t2_addr1", mem_addr, 32'h300); chk("t2_p1_go", p1_stall, 0);
    chk("t2_p1_rdata", p1_rdata, 32'hCAFEF00D);
    step(); p1_cen = 1'b0;
    step();
    // P0 hogging while P1 waits
    p0_cen = 1'b1; p0_addr = 32'h400; p0_ben = 4'hf; p1_cen = 1'b1; p1_addr = 32'h500;
    n0 = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      at();
      if (mem_cen) begin
        if (mem_addr == 32'h500) seen = 1'b1;
        else n0++;
      end
      step();
    end
    p0_cen = 1'b0; p1_cen = 1'b0;
    chk("t3_p1_served", seen, 1);
    chk("t3_p0_grants", n0, EXP_RUN);
    step();
    // P1 stalled three cycles then errors; P0 joins meanwhile
    p1_cen = 1'b1; p1_addr = 32'h600; mem_stall = 1'b1; mem_error = 1'b1; mem_rdata = 32'h0BADF00D;
    at();
    step();
    p0_cen = 1'b1; p0_addr = 32'h700;
    for (int i = 0; i < 3; i++) begin
      at(); chk("t4_p1_stall", p1_stall, 1); chk("t4_p1_err_early", p1_error, 0);
      chk("t4_p0_stall", p0_stall, 1);
      step();
    end
    mem_stall = 1'b0;
    at(); chk("t4_p1_error", p1_error, 1); chk("t4_p1_go", p1_stall, 0);
    chk("t4_p0_error", p0_error, 0); chk("t4_rdata", p1_rdata, 32'h0BADF00D);
    step(); p1_cen = 1'b0; mem_error = 1'b0;
    at(); chk("t4_err_clr", p1_error, 0);
    step();
    at(); chk("t4_p0_addr", mem_addr, 32'h700); chk("t4_p0_go", p0_stall, 0);
    step(); p0_cen = 1'b0;
    step();
    // P1 abort while stalled, pending P0 follows
    p1_cen = 1'b1; p1_addr = 32'h800; mem_stall = 1'b1;
    at();
    step();
    p0_cen = 1'b1; p0_addr = 32'h900;
    at(); chk("t5_own1", mem_cen, 1);
    step(); p1_cen = 1'b0;
    at(); chk("t5_abort_cen", mem_cen, 0); chk("t5_abort_err", p1_error, 0);
    step();
    at(); chk("t5_idle_cen", mem_cen, 0); chk("t5_p0_wait", p0_stall, 1);
    step(); mem_stall = 1'b0;
    at(); chk("t5_p0_cen", mem_cen, 1); chk("t5_p0_addr", mem_addr, 32'h900);
    step(); p0_cen = 1'b0;
    step();
    // asynchronous reset in the middle of an OWN0 cycle
    p0_cen = 1'b1; p0_addr = 32'hA00; mem_stall = 1'b1;
    at();
    step();
    #1; chk("t6_pre_rst", mem_cen, 1);
    #1; g_resetn = 1'b0;
    #1; chk("t6_rst_cen", mem_cen, 0); chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_stall", p0_stall, 1);
    step(); g_resetn = 1'b1; mem_stall = 1'b0;
    at(); chk("t6_idle", mem_cen, 0);
    step();
    at(); chk("t6_regrant", mem_cen, 1); chk("t6_p0_go", p0_stall, 0);
    step(); p0_cen = 1'b0;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
